lac_beacon_tx: RTL
==================

# lac_beacon_tx

Sequential transmitter for the three-colour Voronoi band network. It converts leader-activation pulses (`pRepLeaderRed/Green/Yellow`) into timed `lacX` (near-field) and `lacMX` (relay/medium-field) signal waveforms. These are the signals the band detectors consume; a band is active when both are low. Global mutual exclusion of emission keeps two colours from seeding a band boundary at the same time.

## Interface
Parameters:
- `EMIT_CYCLES`, 8: cycles `lacX` is held high per accepted trigger (1..2^CNT_W-1)
- `RELAY_CYCLES`, 16: cycles `lacMX` is held high after emission (1..2^CNT_W-1)
- `REFRACT_CYCLES`, 4: quiet cycles after relay; triggers ignored (1..2^CNT_W-1)
- `CNT_W`, 8: per-channel countdown width

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `pRepLeaderRed` / `pRepLeaderGreen` / `pRepLeaderYellow`  in  1 each  leader activation trigger, level sampled each edge
- `deadRed` / `deadGreen` / `deadYellow`  in  1 each  channel kill
- `lacRed` / `lacGreen` / `lacYellow`  out  1 each  near-field signal, registered
- `lacMRed` / `lacMGreen` / `lacMYellow`  out  1 each  relay signal, registered
- `busy`  out  3  per-channel not-IDLE, bit0=Red, bit1=Green, bit2=Yellow
- `trigDrop`  out  1  one-cycle pulse when any asserted trigger is not accepted

## Operation
- Per-channel FSM with states IDLE, EMIT, RELAY, REFRACT.
  - IDLE -> EMIT on accepted trigger; load counter with EMIT_CYCLES-1.
  - EMIT -> RELAY when counter==0; load RELAY_CYCLES-1.
  - RELAY -> REFRACT when counter==0; load REFRACT_CYCLES-1.
  - REFRACT -> IDLE when counter==0.
- Outputs decode from state: `lacX`=1 only in EMIT; `lacMX`=1 only in RELAY.
- Acceptance: a trigger is accepted only if its channel is IDLE, its `deadX` is low, and no channel is in EMIT or entering EMIT this edge.
- Simultaneous acceptable triggers resolve by fixed priority Red > Green > Yellow. Losers are dropped.
- `trigDrop` pulses the cycle after any asserted trigger is not accepted, whatever the reason: busy channel, global lock, lost priority, or dead. Triggers are not queued.
- `deadX` high in EMIT or RELAY forces REFRACT next edge with a fresh REFRACT_CYCLES-1 load. In IDLE or REFRACT it has no state effect.
- Counters never wrap: a load happens on every state entry, and decrement occurs only when nonzero.

## Timing
- Reset: all FSMs IDLE, counters 0, all `lac*`/`lacM*` 0, `busy`=0, `trigDrop`=0. Reset mid-emission clears all outputs immediately (asynchronously).
- Trigger sampled at edge N -> `lacX` high from edge N+1 for exactly EMIT_CYCLES cycles.
- `lacMX` follows immediately with no gap cycle, for RELAY_CYCLES cycles.
- Then REFRACT_CYCLES cycles of silence.
- Earliest re-trigger of the same channel is accepted at edge N+EMIT+RELAY+REFRACT.
- Another channel may be accepted at the first edge where the emitting channel's EMIT counter is 0 (overlaps its RELAY).
- Trigger held high continuously re-arms automatically after REFRACT (level sampled, not edge detected).

## Configuration
- `LAC_BEACON_RELAY_EN` defined: full four-state behaviour as above.
- Undefined: RELAY state and counter load removed. EMIT -> REFRACT directly, `lacM*` tied 0, RELAY_CYCLES unused. A dead in EMIT still forces REFRACT.

## Structure
- Package `voronoi_pkg`:
  - `beacon_state_t` enum (IDLE, EMIT, RELAY, REFRACT)
  - colour index constants `COL_RED`=0, `COL_GREEN`=1, `COL_YELLOW`=2
- Sub-module `beacon_channel`: one FSM plus counter, instantiated three times.
  - Inputs: `accept`, `dead`.
  - Outputs: `lac`, `lacM`, `busy`, `in_emit`.
- The top holds the priority/lock arbiter and the `trigDrop` register.

## Test plan
- Reset, then a single 1-cycle `pRepLeaderRed` -> `lacRed` high for 8 cycles, `lacMRed` high for the next 16, then 4 quiet cycles; `busy[0]` low after 28 cycles; `trigDrop` never pulses.
- Red, Green and Yellow triggers on the same edge -> only Red emits, `trigDrop` one pulse. Green retried while Red is in EMIT -> dropped. Retried at Red's cycle 8 -> accepted, `lacGreen` high while `lacMRed` high.
- `deadRed` asserted at EMIT cycle 3 -> `lacRed` low next cycle, no `lacMRed`, 4 quiet cycles, then IDLE.
- `pRepLeaderYellow` held high permanently -> periodic waveform with period 28 (8 lac, 16 lacM, 4 quiet). `trigDrop` pulses on every cycle the trigger is not accepted: 27 of every 28 cycles.
- `rst_n` low at RELAY cycle 5 -> all outputs 0 immediately. After release, a new trigger produces the full 8/16/4 sequence.
- `LAC_BEACON_RELAY_EN` undefined: single trigger -> 8 cycles `lacRed`, 4 quiet, IDLE at cycle 12; `lacM*` constant 0.

Source files
------------

// File: rtl/voronoi_pkg.sv
// Shared types and colour indices for the Voronoi band beacon transmitter.
package voronoi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        RELAY,
        REFRACT
    } beacon_state_t;

    localparam int COL_RED    = 0;
    localparam int COL_GREEN  = 1;
    localparam int COL_YELLOW = 2;

endpackage

// File: rtl/beacon_channel.sv
// One beacon colour: IDLE/EMIT/RELAY/REFRACT sequencer with a non-wrapping countdown.
// The RELAY phase exists only when LAC_BEACON_RELAY_EN is defined.
module beacon_channel
    import voronoi_pkg::*;
#(
    parameter int EMIT_CYCLES    = 8,
    parameter int RELAY_CYCLES   = 16,
    parameter int REFRACT_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    input  logic dead,
    output logic lac,
    output logic lacM,
    output logic busy,
    output logic in_emit,
    output logic ready
);

    localparam logic [CNT_W-1:0] L_EMIT    = CNT_W'(EMIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_REFRACT = CNT_W'(REFRACT_CYCLES - 1);
`ifdef LAC_BEACON_RELAY_EN
    localparam logic [CNT_W-1:0] L_RELAY   = CNT_W'(RELAY_CYCLES - 1);
`endif

    beacon_state_t    r_state;
    beacon_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_zero;
    logic             r_lac;
    logic             r_busy;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
        case (r_state)
            IDLE: begin
                if (accept) begin
                    w_state_nxt = EMIT;
                    w_cnt_nxt   = L_EMIT;
                end
            end
            EMIT: begin
                if (dead) begin
                    w_state_nxt = REFRACT;
                    w_cnt_nxt   = L_REFRACT;
                end else if (w_cnt_zero) begin
`ifdef LAC_BEACON_RELAY_EN
                    w_state_nxt = RELAY;
                    w_cnt_nxt   = L_RELAY;
`else
                    w_state_nxt = REFRACT;
                    w_cnt_nxt   = L_REFRACT;
`endif
                end
            end
`ifdef LAC_BEACON_RELAY_EN
            RELAY: begin
                if (dead || w_cnt_zero) begin
                    w_state_nxt = REFRACT;
                    w_cnt_nxt   = L_REFRACT;
                end
            end
`endif
            REFRACT: begin
                // The final refractory edge may hand straight over to a new emission.
                if (w_cnt_zero) begin
                    if (accept) begin
                        w_state_nxt = EMIT;
                        w_cnt_nxt   = L_EMIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lac   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lac   <= (w_state_nxt == EMIT);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

`ifdef LAC_BEACON_RELAY_EN
    logic r_lacM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lacM <= 1'b0;
        end else begin
            r_lacM <= (w_state_nxt == RELAY);
        end
    end

    assign lacM = r_lacM;
`else
    assign lacM = 1'b0;
`endif

    assign lac     = r_lac;
    assign busy    = r_busy;
    // Locks other colours only while EMIT continues past the coming edge.
    assign in_emit = (r_state == EMIT) && !w_cnt_zero;
    assign ready   = (r_state == IDLE) || ((r_state == REFRACT) && w_cnt_zero);

endmodule

// File: rtl/lac_beacon_tx.sv
// Three-colour lac/lacM beacon transmitter with global emission lock and fixed priority.
// Define LAC_BEACON_RELAY_EN to enable the lacM relay phase.
module lac_beacon_tx
    import voronoi_pkg::*;
#(
    parameter int EMIT_CYCLES    = 8,
    parameter int RELAY_CYCLES   = 16,
    parameter int REFRACT_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pRepLeaderRed,
    input  logic       pRepLeaderGreen,
    input  logic       pRepLeaderYellow,
    input  logic       deadRed,
    input  logic       deadGreen,
    input  logic       deadYellow,
    output logic       lacRed,
    output logic       lacGreen,
    output logic       lacYellow,
    output logic       lacMRed,
    output logic       lacMGreen,
    output logic       lacMYellow,
    output logic [2:0] busy,
    output logic       trigDrop
);

    logic [2:0] w_trig;
    logic [2:0] w_dead;
    logic [2:0] w_ready;
    logic [2:0] w_in_emit;
    logic [2:0] w_cand;
    logic [2:0] w_accept;
    logic [2:0] w_lac;
    logic [2:0] w_lacM;
    logic [2:0] w_busy;
    logic       w_lock;
    logic       r_trig_drop;

    assign w_trig = {pRepLeaderYellow, pRepLeaderGreen, pRepLeaderRed};
    assign w_dead = {deadYellow, deadGreen, deadRed};

    assign w_lock = |w_in_emit;
    assign w_cand = w_trig & w_ready & ~w_dead & {3{~w_lock}};

    assign w_accept[COL_RED]    = w_cand[COL_RED];
    assign w_accept[COL_GREEN]  = w_cand[COL_GREEN] & ~w_cand[COL_RED];
    assign w_accept[COL_YELLOW] = w_cand[COL_YELLOW] & ~w_cand[COL_GREEN] & ~w_cand[COL_RED];

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        beacon_channel #(
            .EMIT_CYCLES   (EMIT_CYCLES),
            .RELAY_CYCLES  (RELAY_CYCLES),
            .REFRACT_CYCLES(REFRACT_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .accept (w_accept[gi]),
            .dead   (w_dead[gi]),
            .lac    (w_lac[gi]),
            .lacM   (w_lacM[gi]),
            .busy   (w_busy[gi]),
            .in_emit(w_in_emit[gi]),
            .ready  (w_ready[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_drop <= 1'b0;
        end else begin
            r_trig_drop <= |(w_trig & ~w_accept);
        end
    end

    assign lacRed     = w_lac[COL_RED];
    assign lacGreen   = w_lac[COL_GREEN];
    assign lacYellow  = w_lac[COL_YELLOW];
    assign lacMRed    = w_lacM[COL_RED];
    assign lacMGreen  = w_lacM[COL_GREEN];
    assign lacMYellow = w_lacM[COL_YELLOW];
    assign busy       = w_busy;
    assign trigDrop   = r_trig_drop;

endmodule
